// File: rtl/ring_peak.sv
// ---------------------------------------------------------------------------
// ring_peak -- windowed peak-magnitude detector for a signed ADC stream.
//
// Accepted samples are folded into a running peak of |sample|. Once the
// number of accepted samples reaches the window length latched at the
// window's first sample, the peak is published on ph_ring with a one-cycle
// ph_vld pulse. The next window starts on the very next sample.
//
// Pipeline: acceptance (cycle 0) -> registered magnitude (cycle 1) ->
// peak fold / publish (cycle 2).
//
// Optional feature (macro RING_OFS_EN):
//   defined   : mag = |adc_dat - cfg_ring_ofs| computed in 17 bits,
//               saturated to 65535
//   undefined : mag = |adc_dat| and cfg_ring_ofs is ignored
//
// Ports:
//   clk_sys      in   1  system clock, rising edge
//   rst_n        in   1  synchronous active-low reset
//   adc_dat      in  16  signed ADC sample
//   adc_vld      in   1  adc_dat qualifier
//   cfg_ring_en  in   1  window engine enable (level)
//   cfg_win      in  16  samples per window (0 behaves as 1)
//   cfg_ring_ofs in  16  signed DC offset (RING_OFS_EN only)
//   ph_ring      out 16  peak magnitude of the last completed window
//   ph_vld       out  1  one-cycle pulse qualifying a new ph_ring
//   stu_win_cnt  out 16  completed-window count, wraps
// ---------------------------------------------------------------------------
module ring_peak (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] adc_dat,
    input  logic        adc_vld,
    input  logic        cfg_ring_en,
    input  logic [15:0] cfg_win,
    input  logic [15:0] cfg_ring_ofs,
    output logic [15:0] ph_ring,
    output logic        ph_vld,
    output logic [15:0] stu_win_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [15:0] smp_cnt;      // samples accepted in the current window
    logic [15:0] win_len;      // window length latched at first sample
    logic [15:0] peak;         // running peak of the current window
    logic [15:0] mag_q;        // registered magnitude stage
    logic        mag_vld_q;
    logic        mag_last_q;   // stage holds the window's final sample

    logic        accept;
    logic        discard;
    logic [15:0] cfg_win_eff;
    logic [15:0] win_eff;
    logic [16:0] cnt_inc;
    logic        win_done;
    logic [15:0] mag_d;
    logic [15:0] peak_next;
    logic        publish;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_ring_en)  state_next = RUN;
            RUN:     if (!cfg_ring_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A sample is never taken on the cycle the enable is seen low, so a
        // dropped enable cannot smuggle one more sample into a dead window.
        accept      = (state == RUN) && cfg_ring_en && adc_vld;
        discard     = (state == RUN) && !cfg_ring_en;

        cfg_win_eff = (cfg_win == 16'd0) ? 16'd1 : cfg_win;
        // The first sample of a window uses the live configuration; later
        // samples compare against the value latched with that first sample.
        win_eff     = (smp_cnt == 16'd0) ? cfg_win_eff : win_len;
        cnt_inc     = {1'b0, smp_cnt} + 17'd1;
        win_done    = (cnt_inc == {1'b0, win_eff});

        peak_next   = (mag_q > peak) ? mag_q : peak;
        publish     = mag_vld_q && mag_last_q;
    end

`ifdef RING_OFS_EN
    logic [16:0] diff;
    logic [16:0] diff_abs;

    always_comb begin
        diff     = {adc_dat[15], adc_dat} - {cfg_ring_ofs[15], cfg_ring_ofs};
        diff_abs = diff[16] ? (17'd0 - diff) : diff;
        mag_d    = diff_abs[16] ? 16'hFFFF : diff_abs[15:0];
    end
`else
    logic unused_ofs;
    assign unused_ofs = ^cfg_ring_ofs;

    // Negating 0x8000 in 16 bits yields 0x8000, read unsigned as 32768.
    always_comb begin
        mag_d = adc_dat[15] ? (16'd0 - adc_dat) : adc_dat;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the pipeline stages advance together.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state       <= IDLE;
            smp_cnt     <= 16'd0;
            win_len     <= 16'd0;
            peak        <= 16'd0;
            mag_q       <= 16'd0;
            mag_vld_q   <= 1'b0;
            mag_last_q  <= 1'b0;
            ph_ring     <= 16'd0;
            ph_vld      <= 1'b0;
            stu_win_cnt <= 16'd0;
        end else begin
            state <= state_next;

            // Acceptance and magnitude stage.
            mag_vld_q  <= accept;
            mag_last_q <= accept && win_done;
            if (accept) begin
                mag_q <= mag_d;
            end

            if (discard) begin
                smp_cnt <= 16'd0;
            end else if (accept) begin
                if (smp_cnt == 16'd0) begin
                    win_len <= cfg_win_eff;
                end
                smp_cnt <= win_done ? 16'd0 : cnt_inc[15:0];
            end

            // Peak fold and publish. A completed window still drains after
            // the enable drops; only partial windows are thrown away.
            ph_vld <= publish;
            if (publish) begin
                ph_ring     <= peak_next;
                stu_win_cnt <= stu_win_cnt + 16'd1;
            end

            if (discard || publish) begin
                peak <= 16'd0;
            end else if (mag_vld_q) begin
                peak <= peak_next;
            end
        end
    end

endmodule

// File: tb/tb_ring_peak.sv
module tb_ring_peak;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [15:0] adc_dat;
    logic        adc_vld;
    logic        cfg_ring_en;
    logic [15:0] cfg_win;
    logic [15:0] cfg_ring_ofs;
    logic [15:0] ph_ring;
    logic        ph_vld;
    logic [15:0] stu_win_cnt;

    always #5 clk_sys = ~clk_sys;

    ring_peak dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .adc_dat      (adc_dat),
        .adc_vld      (adc_vld),
        .cfg_ring_en  (cfg_ring_en),
        .cfg_win      (cfg_win),
        .cfg_ring_ofs (cfg_ring_ofs),
        .ph_ring      (ph_ring),
        .ph_vld       (ph_vld),
        .stu_win_cnt  (stu_win_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a window is a list of sample magnitudes; when the
    // list reaches the window length its maximum is scheduled for output
    // one edge after the final sample's acceptance edge.
    // ------------------------------------------------------------------
    typedef struct {
        int val;
        int due;
    } pend_t;

    bit    m_run;
    int    m_win[$];
    int    m_len;
    pend_t m_pend[$];
    int    m_ring;
    int    m_cnt;
    bit    m_vld;
    int    edge_n = 0;
    int    vld_seen;
    int    pulse_edges[$];

    function automatic int mag_of(input logic [15:0] d, input logic [15:0] o);
        int v;
`ifdef RING_OFS_EN
        v = $signed(d) - $signed(o);
`else
        v = $signed(d);
`endif
        if (v < 0) v = -v;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic v,
                              input logic [15:0] d, input logic [15:0] w,
                              input logic [15:0] o);
        int    pk;
        pend_t p;
        edge_n++;
        m_vld = 1'b0;
        if (!r) begin
            m_run = 1'b0;
            m_win.delete();
            m_pend.delete();
            m_ring = 0;
            m_cnt  = 0;
            return;
        end
        if (m_pend.size() > 0 && m_pend[0].due == edge_n) begin
            m_vld  = 1'b1;
            m_ring = m_pend[0].val;
            m_cnt  = (m_cnt + 1) % 65536;
            void'(m_pend.pop_front());
        end
        if (m_run && en && v) begin
            if (m_win.size() == 0) m_len = (w == 16'd0) ? 1 : int'(w);
            m_win.push_back(mag_of(d, o));
            if (m_win.size() == m_len) begin
                pk = 0;
                foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
                p.val = pk;
                p.due = edge_n + 1;
                m_pend.push_back(p);
                m_win.delete();
            end
        end
        if (m_run && !en) m_win.delete();
        m_run = en;
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input logic r, input logic en, input logic v,
                        input logic [15:0] d, input logic [15:0] w,
                        input logic [15:0] o);
        rst_n        = r;
        cfg_ring_en  = en;
        adc_vld      = v;
        adc_dat      = d;
        cfg_win      = w;
        cfg_ring_ofs = o;
        @(posedge clk_sys);
        model_edge(r, en, v, d, w, o);
        #1;
        check("ph_vld",      ph_vld,      m_vld);
        check("ph_ring",     ph_ring,     m_ring);
        check("stu_win_cnt", stu_win_cnt, m_cnt);
        if (ph_vld === 1'b1) begin
            vld_seen++;
            pulse_edges.push_back(edge_n);
        end
    endtask

    task automatic idle(input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 16'd0, w, 16'd0);
    endtask

    typedef struct {
        logic [15:0] dat;
        logic [15:0] exp_ring;
    } vec_t;

    initial begin
        vec_t   tbl[7];
        int     ring_before;
        logic   en_r;
        logic [15:0] w_r;

        tbl[0] = '{16'd100,    16'd100};
        tbl[1] = '{16'hFFFF,   16'd1};
        tbl[2] = '{16'h8000,   16'd32768};
        tbl[3] = '{16'h7FFF,   16'd32767};
        tbl[4] = '{16'd0,      16'd0};
        tbl[5] = '{16'h8001,   16'd32767};
        tbl[6] = '{16'd1234,   16'd1234};

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 16'd0);
        check("rst_ph_ring", ph_ring, 0);
        check("rst_ph_vld",  ph_vld,  0);
        check("rst_win_cnt", stu_win_cnt, 0);

        // Samples in IDLE are ignored; the first enabled edge only enters RUN.
        vld_seen = 0;
        step(1'b1, 1'b0, 1'b1, 16'd500, 16'd1, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd600, 16'd1, 16'd0);
        idle(3, 16'd1);
        check("idle_no_pulse", vld_seen, 0);

        // Four-sample window: peak 300, one pulse, count 1.
        vld_seen = 0;
        step(1'b1, 1'b1, 1'b1, 16'd100,   16'd4, 16'd0);
        step(1'b1, 1'b1, 1'b1, -16'sd300, 16'd4, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd250,   16'd4, 16'd0);
        step(1'b1, 1'b1, 1'b1, -16'sd50,  16'd4, 16'd0);
        check("w4_not_yet", ph_vld, 0);
        idle(1, 16'd4);
        check("w4_vld",  ph_vld, 1);
        check("w4_ring", ph_ring, 300);
        check("w4_cnt",  stu_win_cnt, 1);
        idle(3, 16'd4);
        check("w4_hold", ph_ring, 300);
        check("w4_one_pulse", vld_seen, 1);

        // Single-sample windows from the table.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b1, tbl[i].dat, 16'd1, 16'd0);
            idle(1, 16'd1);
            check("tbl_vld",  ph_vld,  1);
            check("tbl_ring", ph_ring, tbl[i].exp_ring);
        end

        // cfg_win=0 behaves as 1, back-to-back pulses on continuous input.
        vld_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 16'(i * 11 + 3), 16'd0, 16'd0);
        idle(3, 16'd0);
        check("w1_b2b_pulses", vld_seen, 4);

        // cfg_win=2, six continuous samples: three pulses, two cycles apart.
        vld_seen = 0;
        pulse_edges.delete();
        step(1'b1, 1'b1, 1'b1, 16'd10,    16'd2, 16'd0);
        step(1'b1, 1'b1, 1'b1, -16'sd20,  16'd2, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd30,    16'd2, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd5,     16'd2, 16'd0);
        step(1'b1, 1'b1, 1'b1, -16'sd7,   16'd2, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd70,    16'd2, 16'd0);
        idle(3, 16'd2);
        check("w2_pulses", vld_seen, 3);
        check("w2_last_ring", ph_ring, 70);
        if (pulse_edges.size() == 3) begin
            check("w2_gap0", pulse_edges[1] - pulse_edges[0], 2);
            check("w2_gap1", pulse_edges[2] - pulse_edges[1], 2);
        end

        // Enable dropped after 5 of 8 samples: partial window discarded.
        ring_before = ph_ring;
        vld_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 16'd9000, 16'd8, 16'd0);
        step(1'b1, 1'b0, 1'b1, 16'd9000, 16'd8, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0,    16'd8, 16'd0);
        idle(1, 16'd3);
        check("drop_no_pulse", vld_seen, 0);
        check("drop_ring_kept", ph_ring, ring_before);
        step(1'b1, 1'b1, 1'b1, 16'd7,    16'd3, 16'd0);
        step(1'b1, 1'b1, 1'b1, -16'sd9,  16'd3, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd5,    16'd3, 16'd0);
        idle(1, 16'd3);
        check("fresh_vld",  ph_vld, 1);
        check("fresh_ring", ph_ring, 9);

        // Last sample accepted just before the enable drops still drains.
        vld_seen = 0;
        step(1'b1, 1'b1, 1'b1, 16'd44, 16'd1, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0,  16'd1, 16'd0);
        check("drain_vld",  ph_vld, 1);
        check("drain_ring", ph_ring, 44);
        step(1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 16'd0);

`ifdef RING_OFS_EN
        step(1'b1, 1'b1, 1'b1, 16'h8000, 16'd1, 16'h7FFF);
        idle(1, 16'd1);
        check("ofs_sat_ring", ph_ring, 65535);
`endif

        // Reset after 3 of 4 samples: everything cleared, no late pulse.
        vld_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'd2000, 16'd4, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 16'd0);
        check("mid_rst_ring", ph_ring, 0);
        check("mid_rst_cnt",  stu_win_cnt, 0);
        check("mid_rst_vld",  ph_vld, 0);
        idle(4, 16'd4);
        step(1'b1, 1'b1, 1'b1, 16'd1, 16'd4, 16'd0);
        idle(3, 16'd4);
        check("mid_rst_no_pulse", vld_seen, 0);

        // Randomized traffic against the model.
        en_r = 1'b1;
        w_r  = 16'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            if ($urandom_range(0, 24) == 0) w_r = 16'($urandom_range(0, 6));
            step(($urandom_range(0, 299) != 0), en_r, ($urandom_range(0, 9) < 7),
                 16'($urandom), w_r,
`ifdef RING_OFS_EN
                 16'($urandom));
`else
                 16'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_peak.md
RING_PEAK -- requirements
Module: ring_peak

Interface
REQ-001 SHALL have port clk_sys, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port adc_dat, input, 16, signed two's-complement ADC sample.
REQ-004 SHALL have port adc_vld, input, 1, adc_dat valid this cycle (one-cycle qualifier, no backpressure).
REQ-005 SHALL have port cfg_ring_en, input, 1, window engine enable (level).
REQ-006 SHALL have port cfg_win, input, 16, samples per window; 0 treated as 1.
REQ-007 SHALL have port cfg_ring_ofs, input, 16, signed DC offset (used only under RING_OFS_EN).
REQ-008 SHALL have port ph_ring, output, 16, unsigned peak magnitude of last completed window.
REQ-009 SHALL have port ph_vld, output, 1, one-cycle pulse qualifying a new ph_ring.
REQ-010 SHALL have port stu_win_cnt, output, 16, count of completed windows, wraps 65535->0.

Function
REQ-011 SHALL implement states IDLE and RUN; IDLE->RUN when cfg_ring_en=1; RUN->IDLE when cfg_ring_en=0.
REQ-012 SHALL latch cfg_win (0 mapped to 1) at each window start; changes mid-window take effect from the next window.
REQ-013 SHALL accept a sample only in RUN with adc_vld=1; samples in IDLE are ignored.
REQ-014 SHALL compute magnitude in a registered stage one cycle after acceptance: mag = |adc_dat|, with |-32768| = 32768.
REQ-015 SHALL clear the running peak at window start and update peak = max(peak, mag) per accepted sample.
REQ-016 SHALL count accepted samples; on the sample making count = latched cfg_win, the window completes.
REQ-017 SHALL drive ph_ring = final window peak and ph_vld = 1 for exactly one cycle, 2 cycles after the adc_vld cycle of the window's last sample.
REQ-018 SHALL hold ph_ring stable between ph_vld pulses.
REQ-019 SHALL start the next window immediately; a sample on the cycle after a window's last sample SHALL be accepted into the new window (no gap, no sample lost).
REQ-020 SHALL increment stu_win_cnt by 1 in the same cycle ph_vld is asserted.
REQ-021 SHALL, when cfg_ring_en drops mid-window, discard the partial window: no ph_vld, peak and sample count cleared, ph_ring retains its prior value.
REQ-022 SHALL still emit ph_vld for a window whose last sample was accepted before cfg_ring_en dropped (pipeline drains).
REQ-023 SHALL, with cfg_win=1, emit one ph_vld per accepted sample, back-to-back every cycle if adc_vld is continuous.

Reset
REQ-024 SHALL, on rst_n=0 at a clock edge, set state IDLE, ph_ring=0, ph_vld=0, stu_win_cnt=0, peak=0, sample count=0, pipeline valid=0.
REQ-025 SHALL, on reset mid-window, discard all in-flight samples with no ph_vld after reset release.

Configuration
REQ-026 SHALL, with macro RING_OFS_EN defined, compute d = adc_dat - cfg_ring_ofs in 17-bit signed and mag = |d| saturated to 65535.
REQ-027 SHALL, without RING_OFS_EN, ignore cfg_ring_ofs (port kept) and use mag = |adc_dat| per REQ-014.

Verification
REQ-028 SHALL cover: cfg_win=4, samples 100,-300,250,-50 -> single ph_vld, ph_ring=300, stu_win_cnt=1.
REQ-029 SHALL cover: adc_dat=-32768 alone, cfg_win=1 -> ph_ring=32768.
REQ-030 SHALL cover: cfg_win=2, continuous adc_vld, 6 samples -> 3 ph_vld pulses each 2 cycles apart, no sample lost.
REQ-031 SHALL cover: cfg_win=8, cfg_ring_en dropped after 5 samples -> no ph_vld, ph_ring unchanged; re-enable starts fresh window.
REQ-032 SHALL cover: RING_OFS_EN, cfg_ring_ofs=32767, adc_dat=-32768 -> ph_ring=65535 (saturated).
REQ-033 SHALL cover: rst_n=0 pulsed after 3 of 4 samples -> all outputs 0, no ph_vld following release.
